// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the LSU: round-robin grant,
// one outstanding transaction, fetch-kill on flush and a response timeout that reports a bus error.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    input  logic                if_flush_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    output logic                if_err_o,
    input  logic                lsu_req_i,
    input  logic [ADDR_W-1:0]   lsu_addr_i,
    input  logic                lsu_we_i,
    input  logic [DATA_W/8-1:0] lsu_be_i,
    input  logic [DATA_W-1:0]   lsu_wdata_i,
    output logic                lsu_gnt_o,
    output logic                lsu_rvalid_o,
    output logic [DATA_W-1:0]   lsu_rdata_o,
    output logic                lsu_err_o,
    output logic                mem_req_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    input  logic                mem_err_i,
    output logic                busy_o
);

    localparam int BE_W  = DATA_W / 8;
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = (TIMEOUT > 0) ? TMR_W'(TIMEOUT - 1) : '0;
    localparam logic [TMR_W-1:0] TMR_MAX  = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    state_e              state_q;
    owner_e              owner_q;
    owner_e              last_q;
    logic                kill_q;
    logic [TMR_W-1:0]    timer_q;
    logic                mem_req_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic                mem_we_q;
    logic [BE_W-1:0]     mem_be_q;
    logic [DATA_W-1:0]   mem_wdata_q;

    logic                lsu_wins;
    logic                grant_any;
    logic                timeout_hit;
    logic                addr_tmo;
    logic                resp_ok;
    logic                resp_tmo;
    logic                done;
    logic                done_err;
    logic [DATA_W-1:0]   done_data;
    logic                if_killed;
    logic                flush_own;

    // Round robin: the LSU takes a tie unless it was the previous winner.
    assign lsu_wins  = lsu_req_i && !(if_req_i && (last_q == OWN_LSU));
    // Grants are masked while reset is held so every output reads 0 during reset.
    assign grant_any = rst_n && (state_q == S_IDLE) && (if_req_i || lsu_req_i);
    assign if_gnt_o  = grant_any && !lsu_wins;
    assign lsu_gnt_o = grant_any && lsu_wins;

    assign timeout_hit = (TIMEOUT != 0) && (timer_q == TMR_LAST);
    assign addr_tmo    = (state_q == S_ADDR) && !mem_gnt_i && timeout_hit;
    assign resp_ok     = (state_q == S_RESP) && mem_rvalid_i;
    assign resp_tmo    = (state_q == S_RESP) && !mem_rvalid_i && timeout_hit;
    assign done        = resp_ok || addr_tmo || resp_tmo;
    assign done_err    = resp_ok ? mem_err_i : 1'b1;
    assign done_data   = resp_ok ? mem_rdata_i : '0;

    assign flush_own   = if_flush_i && (owner_q == OWN_IF);
    // A flush landing in the same cycle as the response kills that response too.
    assign if_killed   = kill_q || if_flush_i;

    assign if_rvalid_o  = done && (owner_q == OWN_IF) && !if_killed;
    assign if_rdata_o   = if_rvalid_o ? done_data : '0;
    assign if_err_o     = if_rvalid_o && done_err;
    assign lsu_rvalid_o = done && (owner_q == OWN_LSU);
    assign lsu_rdata_o  = lsu_rvalid_o ? done_data : '0;
    assign lsu_err_o    = lsu_rvalid_o && done_err;

    assign mem_req_o   = mem_req_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_we_o    = mem_we_q;
    assign mem_be_o    = mem_be_q;
    assign mem_wdata_o = mem_wdata_q;
    assign busy_o      = (state_q != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_IF;
            last_q      <= OWN_IF;
            kill_q      <= 1'b0;
            timer_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_any) begin
                        state_q   <= S_ADDR;
                        owner_q   <= lsu_wins ? OWN_LSU : OWN_IF;
                        last_q    <= lsu_wins ? OWN_LSU : OWN_IF;
                        kill_q    <= !lsu_wins && if_flush_i;
                        timer_q   <= '0;
                        mem_req_q <= 1'b1;
                        if (lsu_wins) begin
                            mem_addr_q  <= lsu_addr_i;
                            mem_we_q    <= lsu_we_i;
                            mem_be_q    <= lsu_be_i;
                            mem_wdata_q <= lsu_wdata_i;
                        end else begin
                            mem_addr_q  <= if_addr_i;
                            mem_we_q    <= 1'b0;
                            mem_be_q    <= '1;
                            mem_wdata_q <= '0;
                        end
                    end
                end
                S_ADDR: begin
                    if (flush_own) kill_q <= 1'b1;
                    if (mem_gnt_i) begin
                        state_q   <= S_RESP;
                        mem_req_q <= 1'b0;
                        timer_q   <= '0;
                    end else if (addr_tmo) begin
                        state_q   <= S_IDLE;
                        mem_req_q <= 1'b0;
                    end else if (timer_q != TMR_MAX) begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_RESP: begin
                    if (flush_own) kill_q <= 1'b1;
                    if (done) begin
                        state_q <= S_IDLE;
                    end else if (timer_q != TMR_MAX) begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic, every cycle checked
// against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req_i, if_flush_i, lsu_req_i, lsu_we_i;
    logic [AW-1:0] if_addr_i, lsu_addr_i;
    logic [3:0]    lsu_be_i;
    logic [DW-1:0] lsu_wdata_i, mem_rdata_i;
    logic          mem_gnt_i, mem_rvalid_i, mem_err_i;
    logic          if_gnt_o, if_rvalid_o, if_err_o, lsu_gnt_o, lsu_rvalid_o, lsu_err_o;
    logic [DW-1:0] if_rdata_o, lsu_rdata_o, mem_wdata_o;
    logic          mem_req_o, mem_we_o, busy_o;
    logic [AW-1:0] mem_addr_o;
    logic [3:0]    mem_be_o;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
        .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_err_o(if_err_o),
        .lsu_req_i(lsu_req_i), .lsu_addr_i(lsu_addr_i), .lsu_we_i(lsu_we_i), .lsu_be_i(lsu_be_i),
        .lsu_wdata_i(lsu_wdata_i), .lsu_gnt_o(lsu_gnt_o), .lsu_rvalid_o(lsu_rvalid_o),
        .lsu_rdata_o(lsu_rdata_o), .lsu_err_o(lsu_err_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model of the single outstanding transaction (owner: 0 = fetch, 1 = LSU).
    bit            m_busy, m_resp, m_owner, m_last, m_kill, m_req, m_we;
    int            m_age;
    logic [AW-1:0] m_addr;
    logic [3:0]    m_be;
    logic [DW-1:0] m_wdata;

    logic          e_ifg, e_lsg;
    logic          o_ifg, o_lsg, o_ifrv, o_lsrv, o_iferr, o_lserr, o_busy, o_req, o_we;
    logic [DW-1:0] o_ifrd, o_lsrd, o_wd;
    logic [3:0]    o_be;
    bit            if_pend, lsu_pend, fetch_beat;
    int            seq[$];
    int            busy_cnt;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_resp = 0; m_owner = 0; m_last = 0; m_kill = 0; m_req = 0;
        m_we = 0; m_age = 0; m_addr = '0; m_be = '0; m_wdata = '0;
    endtask

    task automatic clear_inputs();
        if_req_i = 0; if_flush_i = 0; lsu_req_i = 0; lsu_we_i = 0;
        if_addr_i = '0; lsu_addr_i = '0; lsu_be_i = '0; lsu_wdata_i = '0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_err_i = 0; mem_rdata_i = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_if_gnt"}, if_gnt_o, 0);   chk({tag, "_lsu_gnt"}, lsu_gnt_o, 0);
        chk({tag, "_if_rv"}, if_rvalid_o, 0); chk({tag, "_lsu_rv"}, lsu_rvalid_o, 0);
        chk({tag, "_if_rd"}, if_rdata_o, 0);  chk({tag, "_lsu_rd"}, lsu_rdata_o, 0);
        chk({tag, "_if_err"}, if_err_o, 0);   chk({tag, "_lsu_err"}, lsu_err_o, 0);
        chk({tag, "_mreq"}, mem_req_o, 0);    chk({tag, "_maddr"}, mem_addr_o, 0);
        chk({tag, "_mwe"}, mem_we_o, 0);      chk({tag, "_mbe"}, mem_be_o, 0);
        chk({tag, "_mwd"}, mem_wdata_o, 0);   chk({tag, "_busy"}, busy_o, 0);
    endtask

    // Called just after a falling edge with inputs already driven; checks, then advances one clock.
    task automatic cycle();
        logic e_ifrv, e_lsrv, e_iferr, e_lserr, derr;
        logic [DW-1:0] e_ifrd, e_lsrd, drd;
        bit done, lsu_wins, timed_out;
        e_ifg = 0; e_lsg = 0; e_ifrv = 0; e_lsrv = 0; e_iferr = 0; e_lserr = 0;
        e_ifrd = '0; e_lsrd = '0; derr = 0; drd = '0; done = 0; lsu_wins = 0;
        #1;
        timed_out = (TMO != 0) && (m_age == TMO - 1);
        if (!m_busy) begin
            if (if_req_i || lsu_req_i) begin
                lsu_wins = lsu_req_i && !(if_req_i && m_last);
                e_lsg = lsu_wins;
                e_ifg = !lsu_wins;
            end
        end else if (!m_resp) begin
            if (!mem_gnt_i && timed_out) begin done = 1; derr = 1; drd = '0; end
        end else begin
            if (mem_rvalid_i) begin done = 1; derr = mem_err_i; drd = mem_rdata_i; end
            else if (timed_out) begin done = 1; derr = 1; drd = '0; end
        end
        if (done && m_owner) begin
            e_lsrv = 1; e_lsrd = drd; e_lserr = derr;
        end else if (done && !m_kill && !if_flush_i) begin
            e_ifrv = 1; e_ifrd = drd; e_iferr = derr;
        end
        o_ifg = if_gnt_o; o_lsg = lsu_gnt_o; o_ifrv = if_rvalid_o; o_lsrv = lsu_rvalid_o;
        o_ifrd = if_rdata_o; o_lsrd = lsu_rdata_o; o_iferr = if_err_o; o_lserr = lsu_err_o;
        o_busy = busy_o; o_req = mem_req_o; o_we = mem_we_o; o_be = mem_be_o; o_wd = mem_wdata_o;
        chk("if_gnt", if_gnt_o, e_ifg);
        chk("lsu_gnt", lsu_gnt_o, e_lsg);
        chk("if_rvalid", if_rvalid_o, e_ifrv);
        chk("lsu_rvalid", lsu_rvalid_o, e_lsrv);
        if (e_ifrv || !(m_busy && !m_owner)) begin
            chk("if_rdata", if_rdata_o, e_ifrd); chk("if_err", if_err_o, e_iferr);
        end
        if (e_lsrv || !(m_busy && m_owner)) begin
            chk("lsu_rdata", lsu_rdata_o, e_lsrd); chk("lsu_err", lsu_err_o, e_lserr);
        end
        chk("busy", busy_o, m_busy);
        chk("mem_req", mem_req_o, m_req);
        chk("mem_addr", mem_addr_o, m_addr);
        chk("mem_we", mem_we_o, m_we);
        chk("mem_be", mem_be_o, m_be);
        chk("mem_wdata", mem_wdata_o, m_wdata);
        @(posedge clk);
        if (!m_busy) begin
            if (e_ifg || e_lsg) begin
                m_busy = 1; m_resp = 0; m_age = 0; m_req = 1;
                m_owner = lsu_wins; m_last = lsu_wins;
                m_kill = !lsu_wins && if_flush_i;
                if (lsu_wins) begin
                    m_addr = lsu_addr_i; m_we = lsu_we_i; m_be = lsu_be_i; m_wdata = lsu_wdata_i;
                end else begin
                    m_addr = if_addr_i; m_we = 0; m_be = 4'hF; m_wdata = '0;
                end
            end
        end else begin
            if (!m_owner && if_flush_i) m_kill = 1;
            if (done) begin
                m_busy = 0; m_req = 0;
            end else if (!m_resp && mem_gnt_i) begin
                m_resp = 1; m_age = 0; m_req = 0;
            end else begin
                m_age++;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        clear_inputs();
        rst_n = 0;
        model_reset();
        #2;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1;

        // Fetch alone: grant, one-cycle bus grant, response two cycles later.
        if_req_i = 1; if_addr_i = 32'h100;
        cycle();
        chk("t1_gnt", o_ifg, 1);
        if_req_i = 0; mem_gnt_i = 1;
        busy_cnt = 0;
        cycle(); busy_cnt += int'(o_busy);
        chk("t1_mreq", o_req, 1);
        mem_gnt_i = 0;
        cycle(); busy_cnt += int'(o_busy);
        mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF;
        cycle(); busy_cnt += int'(o_busy);
        chk("t1_rvalid", o_ifrv, 1);
        chk("t1_rdata", o_ifrd, 32'hDEADBEEF);
        chk("t1_busy_cycles", busy_cnt, 3);
        clear_inputs();
        cycle();

        // Both requesting, zero-wait bus: grants alternate starting with the LSU.
        if_req_i = 1; if_addr_i = 32'h180;
        lsu_req_i = 1; lsu_addr_i = 32'h300; lsu_be_i = 4'h5; lsu_wdata_i = 32'hA5A5;
        mem_gnt_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h55;
        fetch_beat = 0;
        for (int c = 0; c < 12; c++) begin
            cycle();
            if (fetch_beat) begin
                chk("t2_fetch_be", o_be, 4'hF);
                chk("t2_fetch_wd", o_wd, 0);
            end
            fetch_beat = o_ifg;
            if (o_lsg) seq.push_back(1);
            if (o_ifg) seq.push_back(0);
        end
        chk("t2_ngrants", seq.size(), 4);
        for (int i = 0; i < seq.size(); i++) chk("t2_order", seq[i], (i % 2 == 0) ? 1 : 0);
        clear_inputs();
        cycle();

        // LSU store with a bus error on the response.
        lsu_req_i = 1; lsu_addr_i = 32'h200; lsu_we_i = 1; lsu_be_i = 4'h3; lsu_wdata_i = 32'h1234;
        cycle();
        chk("t3_gnt", o_lsg, 1);
        lsu_req_i = 0;
        cycle();
        chk("t3_we", o_we, 1);
        chk("t3_be", o_be, 4'h3);
        mem_gnt_i = 1;
        cycle();
        mem_gnt_i = 0; mem_rvalid_i = 1; mem_err_i = 1; mem_rdata_i = 32'h77;
        cycle();
        chk("t3_rvalid", o_lsrv, 1);
        chk("t3_err", o_lserr, 1);
        clear_inputs();
        cycle();

        // Flush during a fetch response: the response is swallowed, next fetch proceeds.
        if_req_i = 1; if_addr_i = 32'h400;
        cycle();
        if_req_i = 0; mem_gnt_i = 1;
        cycle();
        mem_gnt_i = 0; if_flush_i = 1;
        cycle();
        if_flush_i = 0;
        cycle(); cycle();
        mem_rvalid_i = 1; mem_rdata_i = 32'h99;
        cycle();
        chk("t4_suppressed", o_ifrv, 0);
        mem_rvalid_i = 0;
        cycle();
        chk("t4_idle", o_busy, 0);
        if_req_i = 1; if_addr_i = 32'h404;
        cycle();
        chk("t4_regrant", o_ifg, 1);
        if_req_i = 0; mem_gnt_i = 1;
        cycle();
        mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hABCD;
        cycle();
        chk("t4_rvalid", o_ifrv, 1);
        chk("t4_rdata", o_ifrd, 32'hABCD);
        clear_inputs();
        cycle();

        // Bus never grants: timeout after TMO cycles in the address phase.
        lsu_req_i = 1; lsu_addr_i = 32'h500; lsu_be_i = 4'hF;
        cycle();
        lsu_req_i = 0;
        for (int c = 0; c < TMO; c++) begin
            cycle();
            if (c < TMO - 1) chk("t5_wait", o_lsrv, 0);
        end
        chk("t5_rvalid", o_lsrv, 1);
        chk("t5_err", o_lserr, 1);
        chk("t5_rdata", o_lsrd, 0);
        mem_rvalid_i = 1; mem_rdata_i = 32'hBAD;
        cycle();
        chk("t5_late_rv", o_lsrv, 0);
        chk("t5_mreq", o_req, 0);
        chk("t5_idle", o_busy, 0);
        clear_inputs();
        cycle();

        // Asynchronous reset while a response is pending.
        if_req_i = 1; if_addr_i = 32'h600;
        lsu_req_i = 1; lsu_addr_i = 32'h700; lsu_be_i = 4'hC;
        cycle();
        chk("t6_if_first", o_ifg, 1);
        mem_gnt_i = 1;
        cycle();
        mem_gnt_i = 0;
        #2 rst_n = 0;
        #1 chk_all_zero("t6_async");
        model_reset();
        @(negedge clk);
        rst_n = 1;
        cycle();
        chk("t6_lsu_first", o_lsg, 1);
        lsu_req_i = 0;
        if_pend = 1; lsu_pend = 0;

        // Random traffic; requesters hold their request until the model says they were granted.
        for (int c = 0; c < 3000; c++) begin
            if (!if_pend && $urandom_range(0, 2) == 0) begin
                if_pend = 1; if_addr_i = $urandom & 32'hFFFF_FFFC;
            end
            if (!lsu_pend && $urandom_range(0, 2) == 0) begin
                lsu_pend = 1; lsu_addr_i = $urandom; lsu_we_i = 1'($urandom);
                lsu_be_i = 4'($urandom); lsu_wdata_i = $urandom;
            end
            if_req_i = if_pend; lsu_req_i = lsu_pend;
            if_flush_i = ($urandom_range(0, 7) == 0);
            mem_gnt_i = m_busy && !m_resp && ($urandom_range(0, 2) == 0);
            mem_rvalid_i = ($urandom_range(0, 2) == 0);
            mem_rdata_i = $urandom;
            mem_err_i = ($urandom_range(0, 3) == 0);
            cycle();
            if (e_ifg) if_pend = 0;
            if (e_lsg) lsu_pend = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
